// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned MEM_LAT_DEFAULT = 2;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 4;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    IO_ACC  = 2'd2
  } arb_state_e;

  // Command latched at grant and held on the memory port for the whole access
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_lat_timer.sv
// Memory-latency down-counter: loads on grant, counts down to zero, then holds.
module dmem_lat_timer
  import dmem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU MEM-stage and IO/loader accesses onto a single fixed-latency data-memory port.
// Define DMEM_ARB_RR_EN for round-robin on contention; the default build gives the CPU fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic             grant_cpu_c;
  logic             grant_io_c;
  logic             fin_cpu_c;
  logic             fin_io_c;
  logic             io_pri_c;
  logic [CNT_W-1:0] lat_cnt;
  logic             lat_zero_c;
  logic             cpu_done;
  mem_cmd_t         cmd_q;

`ifdef DMEM_ARB_RR_EN
  // Reset as if the CPU was served last, so IO wins the first contested grant.
  logic last_io;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_io <= 1'b0;
    end else if (grant_cpu_c || grant_io_c) begin
      last_io <= grant_io_c;
    end
  end

  assign io_pri_c = ~last_io;
`else
  assign io_pri_c = 1'b0;
`endif

  dmem_lat_timer u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_cpu_c | grant_io_c),
    .load_val (CNT_W'(MEM_LAT)),
    .dec      (state != IDLE),
    .count    (lat_cnt),
    .zero_c   (lat_zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion is flagged one cycle early so its registered pulse lands on the zero-count cycle.
  always_comb begin
    state_nxt   = state;
    grant_cpu_c = 1'b0;
    grant_io_c  = 1'b0;
    fin_cpu_c   = 1'b0;
    fin_io_c    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && !(io_req && io_pri_c)) begin
          grant_cpu_c = 1'b1;
          state_nxt   = CPU_ACC;
        end else if (io_req) begin
          grant_io_c = 1'b1;
          state_nxt  = IO_ACC;
        end
      end
      CPU_ACC: begin
        fin_cpu_c = (lat_cnt == CNT_W'(1));
        if (lat_zero_c) state_nxt = IDLE;
      end
      IO_ACC: begin
        fin_io_c = (lat_cnt == CNT_W'(1));
        if (lat_zero_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command and result registers; an access cut short by rst leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      cmd_q     <= '0;
      cpu_done  <= 1'b0;
      io_ack    <= 1'b0;
      cpu_rdata <= ZERO_WORD;
      io_rdata  <= ZERO_WORD;
    end else begin
      mem_en   <= grant_cpu_c | grant_io_c;
      cpu_done <= fin_cpu_c;
      io_ack   <= fin_io_c;
      if (grant_cpu_c) begin
        cmd_q <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
      end else if (grant_io_c) begin
        cmd_q <= '{we: io_we, addr: io_addr, wdata: io_wdata};
      end
      if (fin_cpu_c && !cmd_q.we) cpu_rdata <= mem_rdata;
      if (fin_io_c && !cmd_q.we) io_rdata <= mem_rdata;
    end
  end

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle sequences,
// latency builds of 1 and 15, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata;

  logic [31:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, io_ack, mem_en, mem_we;

  logic [31:0] cpu_rdata_1, io_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        cpu_stall_1, io_ack_1, mem_en_1, mem_we_1;
  logic [31:0] cpu_rdata_15, io_rdata_15, mem_addr_15, mem_wdata_15, mem_rdata_15;
  logic        cpu_stall_15, io_ack_15, mem_en_15, mem_we_15;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Memory contents: a fixed word at 0x100, an address hash elsewhere.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_A5A5;
  endfunction

  assign mem_rdata    = mem_val(mem_addr);
  assign mem_rdata_1  = mem_val(mem_addr_1);
  assign mem_rdata_15 = mem_val(mem_addr_15);

  dmem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_1), .cpu_stall(cpu_stall_1),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata_1), .io_ack(io_ack_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1)
  );

  dmem_arbiter #(.MEM_LAT(15)) dut_lat15 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_15), .cpu_stall(cpu_stall_15),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata_15), .io_ack(io_ack_15),
    .mem_en(mem_en_15), .mem_we(mem_we_15), .mem_addr(mem_addr_15), .mem_wdata(mem_wdata_15),
    .mem_rdata(mem_rdata_15)
  );

  // Transaction-level reference: an access granted at cycle c occupies c+1..c+1+LAT,
  // pulses its owner on the last of those cycles, and the next grant may come one cycle later.
  logic        m_busy, m_own_io, m_cpu_done, m_io_ack, m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_crd, m_ird;
  int          m_done_at;

`ifdef DMEM_ARB_RR_EN
  logic m_prefer_io;
  wire  m_pick_io = io_req && (!cpu_req || m_prefer_io);
`else
  wire  m_pick_io = !cpu_req;
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0; m_cpu_done <= 1'b0; m_io_ack <= 1'b0; m_en <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_crd <= '0; m_ird <= '0; m_own_io <= 1'b0; m_done_at <= 0;
`ifdef DMEM_ARB_RR_EN
      m_prefer_io <= 1'b1;
`endif
    end else begin
      m_en <= 1'b0; m_cpu_done <= 1'b0; m_io_ack <= 1'b0;
      if (m_busy) begin
        if (cyc + 1 == m_done_at) begin
          if (m_own_io) begin
            m_io_ack <= 1'b1;
            if (!m_we) m_ird <= mem_val(m_addr);
          end else begin
            m_cpu_done <= 1'b1;
            if (!m_we) m_crd <= mem_val(m_addr);
          end
        end
        if (cyc == m_done_at) m_busy <= 1'b0;
      end else if (cpu_req || io_req) begin
        m_busy    <= 1'b1;
        m_own_io  <= m_pick_io;
        m_done_at <= cyc + 1 + int'(LAT);
        m_en      <= 1'b1;
        m_we      <= m_pick_io ? io_we    : cpu_we;
        m_addr    <= m_pick_io ? io_addr  : cpu_addr;
        m_wdata   <= m_pick_io ? io_wdata : cpu_wdata;
`ifdef DMEM_ARB_RR_EN
        m_prefer_io <= !m_pick_io;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_all(input logic e_stall, input logic e_ack, input logic e_en, input logic e_we,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [31:0] e_crd, input logic [31:0] e_ird);
    check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    check("io_ack",    32'(io_ack),    32'(e_ack));
    check("mem_en",    32'(mem_en),    32'(e_en));
    check("mem_we",    32'(mem_we),    32'(e_we));
    check("mem_addr",  mem_addr,       e_addr);
    check("mem_wdata", mem_wdata,      e_wdata);
    check("cpu_rdata", cpu_rdata,      e_crd);
    check("io_rdata",  io_rdata,       e_ird);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;
  endtask

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr;
    logic        ireq, iwe;
    logic [31:0] iaddr, iwdata;
    logic        e_stall, e_ack, e_en, e_we;
    logic [31:0] e_addr, e_wdata, e_crd, e_ird;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] d, m, w;
    int          first_2, first_1, first_15;
    bit          pulse, own_io;

    d = 32'hDEADBEEF;
    m = mem_val(32'h80);
    w = 32'h12345678;
    // CPU read of 0x100, IO write of 0x40, IO read of 0x80 whose req drops after one cycle
    tbl[0]  = '{0,0,32'h0,   0,0,32'h0, 32'h0,  0,0,0,0, 32'h0,   32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1,0,32'h100, 0,0,32'h0, 32'h0,  1,0,0,0, 32'h0,   32'h0, 32'h0, 32'h0};
    tbl[2]  = '{1,0,32'h100, 0,0,32'h0, 32'h0,  1,0,1,0, 32'h100, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{1,0,32'h100, 0,0,32'h0, 32'h0,  1,0,0,0, 32'h100, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1,0,32'h100, 0,0,32'h0, 32'h0,  0,0,0,0, 32'h100, 32'h0, d,     32'h0};
    tbl[5]  = '{0,0,32'h0,   0,0,32'h0, 32'h0,  0,0,0,0, 32'h100, 32'h0, d,     32'h0};
    tbl[6]  = '{0,0,32'h0,   1,1,32'h40,w,      0,0,0,0, 32'h100, 32'h0, d,     32'h0};
    tbl[7]  = '{0,0,32'h0,   1,1,32'h40,w,      0,0,1,1, 32'h40,  w,     d,     32'h0};
    tbl[8]  = '{0,0,32'h0,   1,1,32'h40,w,      0,0,0,1, 32'h40,  w,     d,     32'h0};
    tbl[9]  = '{0,0,32'h0,   1,1,32'h40,w,      0,1,0,1, 32'h40,  w,     d,     32'h0};
    tbl[10] = '{0,0,32'h0,   0,0,32'h0, 32'h0,  0,0,0,1, 32'h40,  w,     d,     32'h0};
    tbl[11] = '{0,0,32'h0,   1,0,32'h80,32'h0,  0,0,0,1, 32'h40,  w,     d,     32'h0};
    tbl[12] = '{0,0,32'h0,   0,0,32'h80,32'h0,  0,0,1,0, 32'h80,  32'h0, d,     32'h0};
    tbl[13] = '{0,0,32'h0,   0,0,32'h80,32'h0,  0,0,0,0, 32'h80,  32'h0, d,     32'h0};
    tbl[14] = '{0,0,32'h0,   0,0,32'h80,32'h0,  0,1,0,0, 32'h80,  32'h0, d,     m};
    tbl[15] = '{0,0,32'h0,   0,0,32'h0, 32'h0,  0,0,0,0, 32'h80,  32'h0, d,     m};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = '0;
      io_req = tbl[i].ireq; io_we = tbl[i].iwe; io_addr = tbl[i].iaddr; io_wdata = tbl[i].iwdata;
      @(negedge clk);
      check_all(tbl[i].e_stall, tbl[i].e_ack, tbl[i].e_en, tbl[i].e_we,
                tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_crd, tbl[i].e_ird);
      tick();
    end

    // Reset two cycles into a CPU read: no completion, rdata cleared, port idle
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid stall", 32'(cpu_stall), 32'd1);
    check("rst_mid cpu_rdata", cpu_rdata, 32'h0);
    check("rst_mid mem_en", 32'(mem_en), 32'd0);
    check("rst_mid mem_addr", mem_addr, 32'h0);
    check("rst_mid io_ack", 32'(io_ack), 32'd0);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_mid regrant", 32'(mem_en), 32'd1);
    repeat (6) tick();

    // Both requesters held continuously after reset
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h200;
    io_req  = 1'b1; io_addr  = 32'h300;
    for (int k = 0; k < 16; k++) begin
      pulse  = (k >= 3) && ((k - 3) % 4 == 0);
`ifdef DMEM_ARB_RR_EN
      own_io = (((k - 3) / 4) % 2) == 0;
`else
      own_io = 1'b0;
`endif
      @(negedge clk);
      check("contend stall", 32'(cpu_stall), 32'(!(pulse && !own_io)));
      check("contend io_ack", 32'(io_ack), 32'(pulse && own_io));
      tick();
    end
    @(negedge clk);
    check("contend cpu_rdata", cpu_rdata, mem_val(32'h200));
`ifdef DMEM_ARB_RR_EN
    check("contend io_rdata", io_rdata, mem_val(32'h300));
`else
    check("contend io_rdata", io_rdata, 32'h0);
`endif
    tick();

    // Completion latency of the LAT=1, 2 and 15 builds for one CPU read
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h100;
    first_1 = -1; first_2 = -1; first_15 = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (first_1  < 0 && !cpu_stall_1)  first_1  = k;
      if (first_2  < 0 && !cpu_stall)    first_2  = k;
      if (first_15 < 0 && !cpu_stall_15) first_15 = k;
      tick();
    end
    check("lat1 completion", 32'(first_1), 32'd2);
    check("lat2 completion", 32'(first_2), 32'd3);
    check("lat15 completion", 32'(first_15), 32'd16);
    check("lat1 cpu_rdata", cpu_rdata_1, 32'hDEADBEEF);
    check("lat15 cpu_rdata", cpu_rdata_15, 32'hDEADBEEF);

    // Randomized traffic, including occasional resets, against the reference model
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 32'($urandom_range(0, 15)) << 4;
      cpu_wdata = $urandom;
      io_req    = ($urandom_range(0, 2) == 0);
      io_we     = $urandom_range(0, 1) == 1;
      io_addr   = 32'($urandom_range(0, 15)) << 4;
      io_wdata  = $urandom;
      @(negedge clk);
      check_all(cpu_req && !m_cpu_done, m_io_ack, m_en, m_we, m_addr, m_wdata, m_crd, m_ird);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory read/write latency in cycles, legal range 1..15.
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1); reset rst, synchronous, active-high.
REQ-003 SHALL have CPU MEM-stage port cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, 32), cpu_wdata (in, 32), cpu_rdata (out, 32), cpu_stall (out, 1, pipeline hold).
REQ-004 SHALL have IO/loader port io_req (in, 1), io_we (in, 1), io_addr (in, 32), io_wdata (in, 32), io_rdata (out, 32), io_ack (out, 1, one-cycle completion pulse).
REQ-005 SHALL have memory port mem_en (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32).

Function
REQ-006 SHALL implement FSM states IDLE, CPU_ACC, IO_ACC.
REQ-007 SHALL, in IDLE with any request, register the winner's we/addr/wdata onto mem_we/mem_addr/mem_wdata, assert mem_en for exactly the next cycle, load a 4-bit latency counter with MEM_LAT, and enter the winner's ACC state.
REQ-008 SHALL decrement the counter once per cycle in an ACC state; completion occurs on the cycle the counter reaches 0.
REQ-009 SHALL, at completion, register mem_rdata into cpu_rdata or io_rdata, pulse internal cpu_done or io_ack for one cycle, and return to IDLE.
REQ-010 SHALL give a request sampled in IDLE at cycle T a completion pulse at cycle T+1+MEM_LAT.
REQ-011 SHALL drive cpu_stall = cpu_req AND NOT cpu_done, combinationally.
REQ-012 SHALL hold mem_en, mem_we, mem_addr, mem_wdata stable for the whole access and drive mem_en=0 outside the grant cycle.
REQ-013 SHALL complete a granted access even if its req drops mid-access; the completion pulse still occurs and is ignored by the requester.
REQ-014 SHALL require requesters to hold req and operands stable until completion; a change mid-access does not affect the current access.
REQ-015 SHALL re-arbitrate only in IDLE, giving one idle cycle between back-to-back accesses.
REQ-016 SHALL leave cpu_rdata and io_rdata unchanged on write accesses and at all times other than their own completion.
REQ-017 SHALL never assert io_ack and cpu_done in the same cycle.

Reset
REQ-018 SHALL, on rst, enter IDLE, clear the counter, drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, io_rdata=0, io_ack=0, and clear the round-robin last-grant flag to IO.
REQ-019 SHALL abort an in-flight access on rst mid-operation: no completion pulse, and no rdata update.

Configuration
REQ-020 SHALL, with DMEM_ARB_RR_EN defined, grant the requester not granted last when both request in IDLE, updating the last-grant flag on every grant.
REQ-021 SHALL, without DMEM_ARB_RR_EN, give the CPU fixed priority; IO is granted only when cpu_req=0 in IDLE, and no last-grant flag is implemented.

Structure
REQ-022 SHALL take state encodings, the MEM_LAT default and the ZeroWord constant from the shared defines.v include.
REQ-023 SHALL place the latency counter in one sub-module, dmem_lat_timer (load, decrement, zero flag); the FSM and muxing stay in dmem_arbiter.

Verification (MEM_LAT=2)
REQ-024 SHALL cover CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x100 at T, mem_rdata=0xDEADBEEF -> mem_en only at T+1, cpu_rdata=0xDEADBEEF and cpu_stall=0 at T+3, cpu_stall=1 at T..T+2.
REQ-025 SHALL cover IO write: io_req=1, io_we=1, io_addr=0x40, io_wdata=0x12345678 -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 held T+1..T+3, io_ack pulse at T+3, io_rdata unchanged.
REQ-026 SHALL cover simultaneous requests held continuously: with DMEM_ARB_RR_EN, grants alternate IO then CPU (after reset) with completion pulses 4 cycles apart; without it, CPU is granted every access and io_ack never pulses.
REQ-027 SHALL cover reset mid-access: rst at T+2 of a CPU read -> IDLE at T+3, no cpu_done, cpu_rdata=0, and mem_en=0.
REQ-028 SHALL cover req drop: io_req deasserted at T+1 -> access still completes, io_ack pulse at T+3, then IDLE.
REQ-029 SHALL cover MEM_LAT=1 and MEM_LAT=15 builds: completion at T+2 and T+16 respectively.
